// File: rtl/color_dispense_seq.sv
`default_nettype none
// ============================================================================
// Module   : color_dispense_seq
// Purpose  : Step-count sequencer in front of the red/yellow/blue stepper
//            drivers. Accepts one dispense request over valid/ready, then runs
//            open (N steps, dir=1), dwell (DWELL_TICKS steps, motors off),
//            close (N steps, dir=0) and a one-cycle DONE on the chosen motor.
// Ports    : clk, rst (async, active-low)
//            step_tick            - one-cycle strobe at the motor step rate
//            req_valid/req_ready  - request handshake (ready only in IDLE)
//            req_color, req_steps - colour (1 red, 2 yellow, 3 blue), N
//            abort                - level; returns the motor to its start
//            en_red/en_yellow/en_blue, dir - registered motor controls
//            busy, done, err      - status (done/err are one-cycle pulses)
// Revision : 1.0 - initial release
// ============================================================================
module color_dispense_seq #(
    parameter int STEP_W      = 10,
    parameter int DWELL_TICKS = 20,
    parameter int DWELL_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_tick,
    input  logic              req_valid,
    input  logic [1:0]        req_color,
    input  logic [STEP_W-1:0] req_steps,
    output logic              req_ready,
    input  logic              abort,
    output logic              en_red,
    output logic              en_yellow,
    output logic              en_blue,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FWD   = 3'd1,
        S_DWELL = 3'd2,
        S_REV   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(DWELL_TICKS - 1);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]   n_q, n_d;
    logic [1:0]          color_q, color_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [2:0]          en_q, en_d;
    logic                dir_q, dir_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [STEP_W-1:0]   w_cnt_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            color_q <= '0;
            dwell_q <= '0;
            en_q    <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            color_q <= color_d;
            dwell_q <= dwell_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        color_d   = color_q;
        dwell_d   = dwell_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        // In FWD a same-cycle tick is counted before an abort is acted on.
        w_cnt_inc = cnt_q + STEP_W'(step_tick);

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_color == 2'd0 || req_steps == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_FWD;
                        color_d = req_color;
                        n_d     = req_steps;
                        cnt_d   = '0;
                    end
                end
            end
            S_FWD: begin
                cnt_d = w_cnt_inc;
                if (abort) begin
                    if (w_cnt_inc == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_REV;
                    end
                end else if (step_tick && w_cnt_inc == n_q) begin
                    state_d = S_DWELL;
                    dwell_d = '0;
                end
            end
            S_DWELL: begin
                if (abort) begin
                    state_d = S_REV;
                    cnt_d   = n_q;
                end else if (step_tick) begin
                    if (dwell_q == c_dwell_last) begin
                        state_d = S_REV;
                    end else begin
                        dwell_d = dwell_q + DWELL_W'(1);
                    end
                end
            end
            S_REV: begin
                if (step_tick) begin
                    cnt_d = cnt_q - STEP_W'(1);
                    if (cnt_q == STEP_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Motor controls are derived from the next state so they switch in
        // the same cycle as the state register.
        en_d = 3'b000;
        if (state_d == S_FWD || state_d == S_REV) begin
            case (color_d)
                2'd1:    en_d = 3'b001;
                2'd2:    en_d = 3'b010;
                2'd3:    en_d = 3'b100;
                default: en_d = 3'b000;
            endcase
        end

        dir_d = dir_q;
        case (state_d)
            S_FWD, S_DWELL: dir_d = 1'b1;
            S_REV, S_DONE:  dir_d = 1'b0;
            default:        dir_d = dir_q;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign en_red    = en_q[0];
    assign en_yellow = en_q[1];
    assign en_blue   = en_q[2];
    assign dir       = dir_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: doc/color_dispense_seq.md
# color_dispense_seq

Step-count sequencer that sits directly upstream of the three stepper motor drivers (red, yellow, blue). It accepts one dispense request at a time over a valid/ready handshake and runs a fixed cycle on the selected motor: open for N steps, dwell, then close for the same number of steps. It drives the per-motor enable and the shared direction line, and replaces the free-running enable counter in the colour test top.

## Interface
- STEP_W, 10: width of the step count and step counter.
- DWELL_TICKS, 20: number of step_tick pulses spent in DWELL; must be at least 1.
- DWELL_W, 8: width of the dwell counter; must satisfy DWELL_TICKS < 2^DWELL_W.

- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous reset, active-low.
- step_tick  input  1  one-cycle strobe at the motor step rate, synchronous to clk.
- req_valid  input  1  request present.
- req_color  input  2  0 = invalid, 1 = red, 2 = yellow, 3 = blue.
- req_steps  input  STEP_W  number of open steps N.
- req_ready  output  1  high only in IDLE; combinational from the state register.
- abort  input  1  level, sampled each cycle.
- en_red / en_yellow / en_blue  output  1 each  motor enables, registered.
- dir  output  1  1 = open (forward), 0 = close; registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at the end of the cycle.
- err  output  1  one-cycle pulse when an accepted request is rejected.

## Operation
- States: IDLE, FWD, DWELL, REV, DONE. Reset enters IDLE.
- Handshake: a request is accepted when req_valid and req_ready are both high. req_color and req_steps are latched in the accept cycle.
- Rejected requests: if the accepted request has req_color == 0 or req_steps == 0, err pulses the next cycle and the block stays in IDLE. No enable asserts.
- IDLE -> FWD: on a valid accept. The step counter cnt is cleared to 0.
- FWD:
  - The selected enable is 1 and dir is 1.
  - Each step_tick increments cnt.
  - When a tick makes cnt equal to N, go to DWELL.
- DWELL:
  - All enables are 0; dir holds at 1.
  - The block counts DWELL_TICKS step_ticks, then goes to REV.
- REV:
  - The selected enable is 1 and dir is 0.
  - Each step_tick decrements cnt.
  - When a tick makes cnt equal to 0, go to DONE.
- DONE: enables are 0 and done is 1 for exactly one cycle, then the block returns to IDLE.
- Abort in FWD: go to REV with the current cnt, so the motor returns to its start position. If the tick and abort arrive in the same cycle, the tick is counted first. If cnt is 0 after that, go straight to DONE.
- Abort in DWELL: go to REV immediately with cnt = N.
- Abort in IDLE, REV or DONE: ignored.
- Only the latched colour's enable may ever be high. At most one enable is high at any time.
- Arithmetic: cnt is STEP_W bits wide and never wraps. It is bounded by 0 and N by construction.

## Timing
- Reset values: en_* = 0, dir = 0, busy = 0, done = 0, err = 0. req_ready reads 1 during and after reset because the state is IDLE.
- If the accept happens in cycle t:
  - State is FWD, busy = 1 and the enable is high from cycle t+1.
  - A step_tick in cycle t is not counted.
- Ticks are counted only in cycles where the state register already holds FWD, DWELL or REV.
- Transition latency: exactly 1 cycle after the deciding step_tick. The enable and dir outputs change in the same cycle as the state.
- Total cycle: N ticks in FWD, DWELL_TICKS ticks in DWELL, N ticks in REV, plus 1 DONE cycle.
- The direction only reverses while enables are 0 (during DWELL). It is never flipped while a motor is enabled, except on an abort from FWD.
- Reset asserted mid-operation forces IDLE and all reset values immediately; it does not wait for a clock edge.
- req_ready is low from t+1 until the cycle after DONE. A held req_valid is accepted on the first IDLE cycle.

## Test plan
- Reset release, then red with N = 3 and ticks every 4 cycles:
  - en_red high for 3 ticks with dir = 1.
  - DWELL lasts 20 ticks with en_red = 0.
  - en_red high for 3 ticks with dir = 0.
  - done pulses once; en_yellow and en_blue stay 0 throughout.
- req_color = 0 with N = 5, and separately blue with N = 0: err pulses 1 cycle, no enable asserts, req_ready stays 1.
- Yellow with N = 10, abort asserted after the 4th FWD tick:
  - The block goes straight to REV.
  - Exactly 4 reverse ticks follow, then done.
- Blue with N = 6, abort during DWELL: REV runs 6 ticks, then done. A second case drives abort and tick together in the first FWD tick: 1 reverse tick, then done.
- Back-to-back requests with req_valid held high: the second request is accepted on the IDLE cycle after done, and req_ready is never high while busy.
- rst driven low mid-REV: all outputs return to reset values immediately, with no clock edge needed. A new request after release runs a full, clean cycle.
